reward_pkt_tx: RTL
==================

Name: reward_pkt_tx

Overview:
- Transmit stage directly downstream of the reward block in the node datapath.
- Takes the reward block's outgoing packet fields (rSourceID … rHopsFromCH) on each reward_done strobe and serializes them into 16-bit words for the radio/link interface, using a valid/ready handshake.
- Word 0 is a header carrying packet type and length. The field words follow; which fields are present depends on the packet type. The last word is an XOR checksum.
- A one-deep shadow slot absorbs a back-to-back reward_done that arrives while a packet is still going out.

Parameters:
- WORD_WIDTH, 16, width of every field and of tx_data.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- nrst  in  1  asynchronous active-low reset.
- reward_done  in  1  single-cycle strobe; the r* inputs are valid in that cycle.
- rPacketType  in  3  packet type.
- rSourceID  in  16  source ID field.
- rDestinationID  in  16  destination ID field.
- rSourceHops  in  16  source hop-count field.
- rQValue  in  16  Q-value field.
- rEnergyLeft  in  16  remaining-energy field.
- rChosenCH  in  16  chosen cluster-head field.
- rHopsFromCH  in  16  hops-from-CH field.
- tx_ready  in  1  link accepts the current word.
- tx_data  out  16  current word.
- tx_valid  out  1  tx_data is valid.
- tx_sop  out  1  current word is the header.
- tx_eop  out  1  current word is the checksum.
- tx_busy  out  1  a packet is active or the shadow slot is full.
- tx_sent  out  1  one-cycle pulse after the checksum is accepted.
- tx_drop  out  1  one-cycle pulse when a request is discarded.

Behaviour:
- Reset is asynchronous, active-low. While nrst=0, all outputs are 0, the FSM is IDLE and the shadow slot is empty.
- Field index order: 0 SRC, 1 DEST, 2 HOPS, 3 Q, 4 ENERGY, 5 CHOSENCH, 6 CHHOPS.
- Fields included per type (ascending index order):
  - 1 HB: SRC, HOPS, Q.
  - 2 CHE: SRC, HOPS, Q, ENERGY.
  - 3 INV: SRC, HOPS, ENERGY, CHHOPS.
  - 4 JOIN: SRC, DEST, CHOSENCH, CHHOPS.
  - 5 DATA: all 7 fields.
  - 6 LOWE: SRC, ENERGY.
  - 0 and 7 are invalid.
- LEN = number of included fields + 2.
- Header word = {type[2:0], 5'b0, LEN[7:0]}.
- Checksum word = XOR of the header and every field word.
- Request acceptance (reward_done=1):
  - Type valid and FSM idle: latch type and all fields into the active registers.
  - FSM busy and shadow empty: latch into the shadow slot.
  - Shadow full, or type invalid: discard and pulse tx_drop on the next cycle.
- FSM states: IDLE, HDR, FIELD, CHK.
  - IDLE→HDR on an accepted request. tx_valid rises in the cycle after the reward_done sample (latency 1).
  - HDR→FIELD on tx_valid & tx_ready.
  - FIELD: advance to the next included field index on each handshake. The step to the next included field takes zero extra cycles, so words are back-to-back. After the last included field, go to CHK.
  - CHK: on handshake, pulse tx_sent the next cycle. Then:
    - If the shadow is full, move shadow→active and go straight to HDR. tx_valid stays high with no bubble.
    - Otherwise go to IDLE.
- Handshake rules:
  - tx_data, tx_sop and tx_eop are stable while tx_valid=1 and tx_ready=0.
  - A word is consumed only on tx_valid & tx_ready.
  - The checksum accumulator updates only on consumed words.
- tx_sop=1 only in HDR; tx_eop=1 only in CHK.
- Simultaneous events:
  - reward_done in the same cycle as the final CHK handshake with the shadow empty: the new request goes to active and the next cycle is HDR (no drop).
  - With the shadow full in that same cycle: the shadow is promoted, the new request goes into the shadow, and nothing is dropped.
- tx_busy = (state≠IDLE) | shadow_full.
- Reset mid-packet aborts immediately. No tx_sent is produced, and the shadow is cleared.

Test Plan:
- HB after reset, tx_ready=1. Inputs: type 1, src 000c, hops 0001, Q 0000. Response: words 2005, 000c, 0001, 0000, 2008 on consecutive cycles; sop on word 1, eop on word 5; tx_sent one cycle after the last word.
- DATA type 5 with fields 0001..0007, tx_ready toggling 1/0. Response: 9 words; header A009; checksum A009^0001^…^0007 = A009 (XOR of 1..7 = 0). Data is held stable on every ready=0 cycle.
- JOIN started, then a second reward_done (HB) during word 2. Response: the HB is shadowed and tx_busy stays 1. HB header 2005 is driven in the cycle after JOIN's checksum handshake, with no tx_valid gap.
- Three requests while busy. Response: the second is shadowed; the third pulses tx_drop; only two packets are emitted.
- Type 0 and type 7 requests while idle. Response: tx_drop pulse, tx_valid stays 0, FSM stays IDLE.
- nrst asserted during the FIELD state of a DATA packet. Response: all outputs 0 asynchronously; after release, a new HB transmits normally starting with 2005.

Source files
------------

// File: rtl/reward_pkt_tx.sv
// reward_pkt_tx: serializes reward-block packets into link words
// (header, type-selected field words, XOR checksum) with a one-deep shadow.
module reward_pkt_tx #(
   parameter int WORD_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  reward_done,
   input  logic [2:0]            rPacketType,
   input  logic [WORD_WIDTH-1:0] rSourceID,
   input  logic [WORD_WIDTH-1:0] rDestinationID,
   input  logic [WORD_WIDTH-1:0] rSourceHops,
   input  logic [WORD_WIDTH-1:0] rQValue,
   input  logic [WORD_WIDTH-1:0] rEnergyLeft,
   input  logic [WORD_WIDTH-1:0] rChosenCH,
   input  logic [WORD_WIDTH-1:0] rHopsFromCH,
   input  logic                  tx_ready,
   output logic [WORD_WIDTH-1:0] tx_data,
   output logic                  tx_valid,
   output logic                  tx_sop,
   output logic                  tx_eop,
   output logic                  tx_busy,
   output logic                  tx_sent,
   output logic                  tx_drop
);

   typedef enum logic [1:0] {
      IDLE,
      HDR,
      FIELD,
      CHK
   } stateT;

   typedef logic [WORD_WIDTH-1:0] wordT;

   stateT      state;
   stateT      nextState;
   logic [2:0] actType;
   logic [2:0] shType;
   wordT       actField [7];
   wordT       shField [7];
   wordT       inField [7];
   logic       shFull;
   logic [2:0] fieldIdx;
   wordT       chkAcc;
   logic       sentQ;
   logic       dropQ;

   logic [6:0] actMask;
   logic [7:0] actLen;
   wordT       hdrWord;
   wordT       fieldWord;
   logic [2:0] nextIdx;
   logic       hasNext;
   logic       hs;
   logic       reqOk;
   logic       loadAct;
   logic       loadSh;
   logic       promote;
   logic       dropReq;
   logic       sentReq;

   // Bit i set = field index i is carried (0 SRC .. 6 CHHOPS)
   function automatic logic [6:0] typeMask(input logic [2:0] t);
      case (t)
         3'd1:    return 7'b0001101;
         3'd2:    return 7'b0011101;
         3'd3:    return 7'b1010101;
         3'd4:    return 7'b1100011;
         3'd5:    return 7'b1111111;
         3'd6:    return 7'b0010001;
         default: return 7'b0000000;
      endcase
   endfunction

   assign inField[0] = rSourceID;
   assign inField[1] = rDestinationID;
   assign inField[2] = rSourceHops;
   assign inField[3] = rQValue;
   assign inField[4] = rEnergyLeft;
   assign inField[5] = rChosenCH;
   assign inField[6] = rHopsFromCH;

   assign reqOk   = reward_done & (rPacketType != 3'd0) & (rPacketType != 3'd7);
   assign actMask = typeMask(actType);
   assign actLen  = 8'($countones(actMask)) + 8'd2;
   assign hdrWord = {actType, {(WORD_WIDTH-11){1'b0}}, actLen};

   assign tx_valid = (state != IDLE);
   assign tx_sop   = (state == HDR);
   assign tx_eop   = (state == CHK);
   assign tx_busy  = (state != IDLE) | shFull;
   assign tx_sent  = sentQ;
   assign tx_drop  = dropQ;
   assign hs       = tx_valid & tx_ready;

   always_comb begin
      fieldWord = '0;
      for (int i = 0; i < 7; i++)
         if (fieldIdx == 3'(i))
            fieldWord = actField[i];
   end

   // Lowest included index above the current one; SRC is always first
   always_comb begin
      hasNext = 1'b0;
      nextIdx = '0;
      for (int i = 6; i >= 0; i--)
         if (actMask[i] && (3'(i) > fieldIdx)) begin
            hasNext = 1'b1;
            nextIdx = 3'(i);
         end
   end

   always_comb begin
      tx_data = '0;
      unique case (state)
         IDLE:  tx_data = '0;
         HDR:   tx_data = hdrWord;
         FIELD: tx_data = fieldWord;
         CHK:   tx_data = chkAcc;
         default: tx_data = '0;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         state <= IDLE;
      else
         state <= nextState;
   end

   always_comb begin
      nextState = state;
      loadAct   = 1'b0;
      loadSh    = 1'b0;
      promote   = 1'b0;
      dropReq   = 1'b0;
      sentReq   = 1'b0;
      unique case (state)
         IDLE: begin
            if (reqOk) begin
               loadAct   = 1'b1;
               nextState = HDR;
            end
         end
         HDR: begin
            if (hs)
               nextState = FIELD;
         end
         FIELD: begin
            if (hs && !hasNext)
               nextState = CHK;
         end
         CHK: begin
            if (hs) begin
               sentReq = 1'b1;
               if (shFull) begin
                  promote   = 1'b1;
                  nextState = HDR;
               end else if (reqOk) begin
                  loadAct   = 1'b1;
                  nextState = HDR;
               end else begin
                  nextState = IDLE;
               end
            end
         end
         default: nextState = IDLE;
      endcase
      // A slot being vacated by promotion can take the new request
      if (reqOk && !loadAct && (state != IDLE)) begin
         if (!shFull || promote)
            loadSh = 1'b1;
         else
            dropReq = 1'b1;
      end
      if (reward_done && !reqOk)
         dropReq = 1'b1;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         actType  <= '0;
         shType   <= '0;
         shFull   <= 1'b0;
         fieldIdx <= '0;
         chkAcc   <= '0;
         sentQ    <= 1'b0;
         dropQ    <= 1'b0;
         for (int i = 0; i < 7; i++) begin
            actField[i] <= '0;
            shField[i]  <= '0;
         end
      end else begin
         sentQ <= sentReq;
         dropQ <= dropReq;
         if (loadAct) begin
            actType  <= rPacketType;
            actField <= inField;
         end else if (promote) begin
            actType  <= shType;
            actField <= shField;
         end
         if (loadSh) begin
            shType  <= rPacketType;
            shField <= inField;
         end
         if (loadSh)
            shFull <= 1'b1;
         else if (promote)
            shFull <= 1'b0;
         if ((state == HDR) && hs) begin
            fieldIdx <= '0;
            chkAcc   <= hdrWord;
         end else if ((state == FIELD) && hs) begin
            chkAcc <= chkAcc ^ fieldWord;
            if (hasNext)
               fieldIdx <= nextIdx;
         end
      end
   end

endmodule
